// File: rtl/button_debouncer.sv
// Mechanical button conditioner: 2-flop synchronizer, stable-sample debounce,
// press/release strobes, press counter and a hold FSM for long-press and auto-repeat.
//
// state | meaning
// IDLE  | button released, hold counter parked at 0
// HELD  | press accepted, counting toward the long-press threshold
// LONG  | long press flagged, counting auto-repeat periods
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES   = 540000,
    parameter int LONG_PRESS_CYCLES = 27000000,
    parameter int REPEAT_CYCLES     = 5400000
) (
    input  logic       clkin_i,
    input  logic       reset_ni,
    input  logic       button_ni,
    output logic       pressed_o,
    output logic       press_pulse_o,
    output logic       release_pulse_o,
    output logic       long_press_o,
    output logic       repeat_pulse_o,
    output logic [7:0] press_count_o
);

    localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    logic              sync_1;
    logic              sync_2;
    logic              db_released;
    logic [DEB_W-1:0]  deb_cnt;
    hold_state_t       state;
    hold_state_t       next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] next_hold;
    logic              long_next;
    logic              repeat_next;
    logic              rise;
    logic              fall;

    always_ff @(posedge clkin_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= button_ni;
            sync_2 <= sync_1;
        end
    end

    // Nth consecutive differing sample toggles the level and clears the count together.
    always_ff @(posedge clkin_i or negedge reset_ni) begin
        if (!reset_ni) begin
            db_released <= 1'b1;
            deb_cnt     <= '0;
        end else if (sync_2 != db_released) begin
            if (deb_cnt == DEB_LAST) begin
                db_released <= ~db_released;
                deb_cnt     <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // pressed_o lags the internal level by one register; the edge between them defines the strobes.
    assign rise = !db_released && !pressed_o;
    assign fall = db_released && pressed_o;

    always_ff @(posedge clkin_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            hold_cnt <= next_hold;
        end
    end

    always_comb begin
        next_state  = state;
        next_hold   = hold_cnt;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        case (state)
            IDLE: begin
                next_hold = '0;
                if (rise) begin
                    next_state = HELD;
                end
            end
            HELD: begin
                if (fall) begin
                    next_state = IDLE;
                    next_hold  = '0;
                end else if (hold_cnt == LONG_LAST) begin
                    next_state = LONG;
                    next_hold  = '0;
                    long_next  = 1'b1;
                end else begin
                    next_hold = hold_cnt + HOLD_W'(1);
                end
            end
            LONG: begin
                if (fall) begin
                    next_state = IDLE;
                    next_hold  = '0;
                end else if (hold_cnt == REP_LAST) begin
                    next_hold   = '0;
                    repeat_next = 1'b1;
                end else begin
                    next_hold = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_hold  = '0;
            end
        endcase
    end

    always_ff @(posedge clkin_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pressed_o       <= 1'b0;
            press_pulse_o   <= 1'b0;
            release_pulse_o <= 1'b0;
            long_press_o    <= 1'b0;
            repeat_pulse_o  <= 1'b0;
            press_count_o   <= 8'd0;
        end else begin
            pressed_o       <= !db_released;
            press_pulse_o   <= rise;
            release_pulse_o <= fall;
            long_press_o    <= long_next;
            repeat_pulse_o  <= repeat_next;
            if (rise) begin
                press_count_o <= press_count_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bounce streams,
// compared every cycle against a sample-run-length reference model.
module tb_button_debouncer;

    localparam int DEB = 16;
    localparam int LP  = 64;
    localparam int RP  = 32;

    logic       clkin_i = 1'b0;
    logic       reset_ni;
    logic       button_ni;
    logic       pressed_o;
    logic       press_pulse_o;
    logic       release_pulse_o;
    logic       long_press_o;
    logic       repeat_pulse_o;
    logic [7:0] press_count_o;

    button_debouncer #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LP),
        .REPEAT_CYCLES    (RP)
    ) dut (
        .clkin_i        (clkin_i),
        .reset_ni       (reset_ni),
        .button_ni      (button_ni),
        .pressed_o      (pressed_o),
        .press_pulse_o  (press_pulse_o),
        .release_pulse_o(release_pulse_o),
        .long_press_o   (long_press_o),
        .repeat_pulse_o (repeat_pulse_o),
        .press_count_o  (press_count_o)
    );

    always #5 clkin_i = ~clkin_i;

    logic [12:0] obs;
    assign obs = {pressed_o, press_pulse_o, release_pulse_o, long_press_o, repeat_pulse_o, press_count_o};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: runs of sampled button levels; an accepted level shows on
    // pressed_o three edges after the sample that completes the run.
    int   m_run;
    logic m_lev;
    logic m_pipe [3];
    logic m_pressed, m_press, m_rel, m_long, m_rep;
    int   m_age;
    int   m_count;

    task automatic model_reset();
        m_run = 0;
        m_lev = 1'b1;
        for (int i = 0; i < 3; i++) m_pipe[i] = 1'b1;
        m_pressed = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_rep = 1'b0;
        m_age = 0;
        m_count = 0;
    endtask

    task automatic model_edge(input logic b);
        logic newp;
        if (b != m_lev) begin
            m_run++;
            if (m_run == DEB) begin
                m_lev = b;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        newp = !m_pipe[2];
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = m_lev;
        m_press = newp && !m_pressed;
        m_rel   = !newp && m_pressed;
        m_pressed = newp;
        if (m_press) begin
            m_count = (m_count + 1) % 256;
            m_age = 0;
        end else if (newp) begin
            m_age++;
        end
        m_long = newp && !m_press && (m_age == LP);
        m_rep  = newp && (m_age > LP) && (((m_age - LP) % RP) == 0);
    endtask

    int cyc = 0;
    int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0;
    int last_press_cyc = 0, last_rel_cyc = 0, last_long_cyc = 0, last_rep_cyc = 0;

    task automatic tick(input logic b);
        logic [12:0] exp;
        button_ni = b;
        @(posedge clkin_i);
        cyc++;
        model_edge(b);
        @(negedge clkin_i);
        exp = {m_pressed, m_press, m_rel, m_long, m_rep, 8'(m_count)};
        check_eq("cycle", 32'(obs), 32'(exp));
        if (press_pulse_o)   begin n_press++; last_press_cyc = cyc; end
        if (release_pulse_o) begin n_rel++;   last_rel_cyc   = cyc; end
        if (long_press_o)    begin n_long++;  last_long_cyc  = cyc; end
        if (repeat_pulse_o)  begin n_rep++;   last_rep_cyc   = cyc; end
    endtask

    task automatic sync_reset();
        reset_ni  = 1'b0;
        button_ni = 1'b1;
        repeat (3) @(negedge clkin_i);
        check_eq("reset_outs", 32'(obs), 32'd0);
        model_reset();
        reset_ni = 1'b1;
    endtask

    task automatic async_reset(input logic b);
        #3 reset_ni = 1'b0;
        #1 check_eq("async_reset", 32'(obs), 32'd0);
        button_ni = b;
        repeat (2) @(negedge clkin_i);
        check_eq("in_reset", 32'(obs), 32'd0);
        model_reset();
        reset_ni = 1'b1;
    endtask

    task automatic bounce_press();
        int t_low, t_high;
        for (int i = 0; i < 10; i++) tick((i % 2) == 0 ? 1'b0 : 1'b1);
        t_low = cyc + 1;
        repeat (20) tick(1'b0);
        for (int i = 0; i < 10; i++) tick((i % 2) == 0 ? 1'b1 : 1'b0);
        t_high = cyc + 1;
        repeat (30) tick(1'b1);
        check_eq("press_latency", 32'(last_press_cyc - t_low), 32'd18);
        check_eq("release_latency", 32'(last_rel_cyc - t_high), 32'd18);
    endtask

    task automatic hold(input int low_len, input int high_len);
        repeat (low_len) tick(1'b0);
        repeat (high_len) tick(1'b1);
    endtask

    initial begin
        int p0, r0, l0, q0, t0, len;
        logic lvl;
        reset_ni  = 1'b0;
        button_ni = 1'b1;
        @(negedge clkin_i);
        sync_reset();
        repeat (5) tick(1'b1);

        // single bounced press/release
        p0 = n_press; r0 = n_rel;
        bounce_press();
        check_eq("one_press", 32'(n_press - p0), 32'd1);
        check_eq("one_release", 32'(n_rel - r0), 32'd1);
        check_eq("count_one", 32'(press_count_o), 32'd1);

        // three bounced presses from reset
        sync_reset();
        p0 = n_press; r0 = n_rel;
        repeat (3) bounce_press();
        check_eq("three_press", 32'(n_press - p0), 32'd3);
        check_eq("three_release", 32'(n_rel - r0), 32'd3);
        check_eq("count_three", 32'(press_count_o), 32'd3);

        // short glitches never accepted
        p0 = n_press; r0 = n_rel;
        hold(1, 30);
        hold(8, 30);
        hold(15, 30);
        check_eq("glitch_press", 32'(n_press - p0), 32'd0);
        check_eq("glitch_release", 32'(n_rel - r0), 32'd0);

        // long hold with auto-repeat
        sync_reset();
        l0 = n_long; q0 = n_rep; r0 = n_rel;
        hold(200, 40);
        check_eq("long_count", 32'(n_long - l0), 32'd1);
        check_eq("long_latency", 32'(last_long_cyc - last_press_cyc), 32'd64);
        check_eq("repeat_count", 32'(n_rep - q0), 32'd4);
        check_eq("repeat_last", 32'(last_rep_cyc - last_long_cyc), 32'd128);
        check_eq("long_release", 32'(n_rel - r0), 32'd1);

        // release coinciding with the long threshold, then with the first repeat
        l0 = n_long; q0 = n_rep;
        hold(64, 40);
        check_eq("rel_beats_long", 32'(n_long - l0), 32'd0);
        l0 = n_long;
        hold(96, 40);
        check_eq("long_before_rep", 32'(n_long - l0), 32'd1);
        check_eq("rel_beats_repeat", 32'(n_rep - q0), 32'd0);

        // reset in the middle of a long press, button still held
        r0 = n_rel;
        repeat (100) tick(1'b0);
        async_reset(1'b0);
        t0 = cyc + 1;
        repeat (30) tick(1'b0);
        check_eq("post_reset_latency", 32'(last_press_cyc - t0), 32'd18);
        check_eq("no_release_on_reset", 32'(n_rel - r0), 32'd0);
        repeat (40) tick(1'b1);

        // reset in the middle of a debounce
        repeat (10) tick(1'b0);
        async_reset(1'b1);
        repeat (30) tick(1'b1);

        // counter wrap
        sync_reset();
        p0 = n_press;
        repeat (256) hold(20, 22);
        check_eq("press_256", 32'(n_press - p0), 32'd256);
        check_eq("count_wrap", 32'(press_count_o), 32'd0);

        // random bounce streams
        lvl = 1'b1;
        for (int s = 0; s < 400; s++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 130)) : int'($urandom_range(1, 40));
            lvl = ~lvl;
            repeat (len) tick(lvl);
        end
        repeat (40) tick(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
